// File: rtl/sd_dma_ahb_sequencer.sv
// rtl/sd_dma_ahb_sequencer.sv - single-beat AHB word mover between SD word streams and memory
//
// Moves a run of 32-bit words between the SD datapath streams and system memory,
// one NONSEQ single transfer at a time, owning the SD controller's AHB master port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_start/write/addr/words run setup, sampled on cfg_start while idle
//   cfg_abort                 stop at the next transfer boundary
//   busy, done, err           run status (done is a 1-cycle pulse, err is sticky)
//   haddr..hexcl, hwdata      AHB master request side
//   hready, hresp, hrdata     AHB master response side
//   src_data/valid/ready      words to be written to memory (src_ready = pop strobe)
//   snk_data/valid/ready      words read from memory (held until snk_ready)
module sd_dma_ahb_sequencer #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int W_CNT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_write,
    input  logic [W_ADDR-1:0] cfg_addr,
    input  logic [W_CNT-1:0]  cfg_words,
    input  logic              cfg_abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W_ADDR-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic              hexcl,
    input  logic              hready,
    input  logic              hresp,
    output logic [W_DATA-1:0] hwdata,
    input  logic [W_DATA-1:0] hrdata,
    input  logic [W_DATA-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [W_DATA-1:0] snk_data,
    output logic              snk_valid,
    input  logic              snk_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [1:0]        HT_IDLE   = 2'b00;
    localparam logic [1:0]        HT_NONSEQ = 2'b10;
    localparam logic [W_ADDR-1:0] ADDR_STEP = W_ADDR'(4);
    localparam logic [W_CNT-1:0]  CNT_ONE   = W_CNT'(1);

    state_t            state;
    logic [W_ADDR-1:0] addr;
    logic [W_CNT-1:0]  cnt;
    logic              dir;
    logic              abort_flag;
    logic              can_launch;
    logic              unused_addr_lsbs;

    // Word addresses only; the byte lane bits of cfg_addr are dropped.
    assign unused_addr_lsbs = ^cfg_addr[1:0];

    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;
    assign hexcl     = 1'b0;

    // Launch only while no NONSEQ is up yet; a read also waits for the previous
    // snk word to have left the register (registered snk_valid gives the 1-cycle gap).
    assign can_launch = (state == S_ADDR) && (htrans == HT_IDLE) && !abort_flag &&
                        (dir ? src_valid : !snk_valid);

    // The source word is consumed in exactly the cycle the write launches.
    assign src_ready = can_launch && dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            abort_flag <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            haddr      <= '0;
            hwrite     <= 1'b0;
            htrans     <= HT_IDLE;
            hwdata     <= '0;
            snk_data   <= '0;
            snk_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (snk_valid && snk_ready) begin
                snk_valid <= 1'b0;
            end
            if (cfg_abort && state != S_IDLE) begin
                abort_flag <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (busy) begin
                        // Only a zero-word run leaves busy set in IDLE: close it out now.
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (cfg_start && !done) begin
                        addr       <= {cfg_addr[W_ADDR-1:2], 2'b00};
                        cnt        <= cfg_words;
                        dir        <= cfg_write;
                        err        <= 1'b0;
                        abort_flag <= 1'b0;
                        busy       <= 1'b1;
                        if (cfg_words != '0) begin
                            state <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    if (htrans == HT_NONSEQ) begin
                        // A NONSEQ on the bus is never withdrawn, abort or not.
                        if (hready) begin
                            htrans <= HT_IDLE;
                            state  <= S_DATA;
                        end
                    end else if (abort_flag) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (can_launch) begin
                        htrans <= HT_NONSEQ;
                        haddr  <= addr;
                        hwrite <= dir;
                        if (dir) begin
                            hwdata <= src_data;
                        end
                    end
                end

                S_DATA: begin
                    if (hready) begin
                        if (hresp) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            if (!dir) begin
                                snk_data  <= hrdata;
                                snk_valid <= 1'b1;
                            end
                            addr <= addr + ADDR_STEP;
                            cnt  <= cnt - CNT_ONE;
                            if (cnt == CNT_ONE || abort_flag) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_ADDR;
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dma_ahb_sequencer.sv
// tb/tb_sd_dma_ahb_sequencer.sv - self-checking bench for sd_dma_ahb_sequencer
module tb_sd_dma_ahb_sequencer;

    localparam logic [31:0] SRC_BASE = 32'hD000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_write, cfg_abort;
    logic [31:0] cfg_addr;
    logic [7:0]  cfg_words;
    logic        busy, done, err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock, hexcl;
    logic        hready, hresp;
    logic [31:0] hwdata, hrdata;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic [31:0] snk_data;
    logic        snk_valid, snk_ready;

    sd_dma_ahb_sequencer #(.W_ADDR(32), .W_DATA(32), .W_CNT(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
        .cfg_words(cfg_words), .cfg_abort(cfg_abort),
        .busy(busy), .done(done), .err(err),
        .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hexcl(hexcl),
        .hready(hready), .hresp(hresp), .hwdata(hwdata), .hrdata(hrdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nonseq_cnt = 0, done_cnt = 0, rd_cnt = 0, src_idx = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] exp_rdata[$];

    bit          dph = 0;
    logic [31:0] dph_addr = '0;
    bit          dph_write = 0;
    int          dph_idx = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic        prev_write = 1'b0;
    logic [31:0] mexp;

    bit stall_en = 0, hold_ready = 0;
    int err_at = -1, err_phase = 0, wait_left = 0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // AHB slave response and source data, driven just after the falling edge.
    initial begin
        hready = 1'b1; hresp = 1'b0; hrdata = '0; src_data = SRC_BASE;
        forever begin
            @(negedge clk);
            #1;
            src_data = SRC_BASE + src_idx;
            hrdata   = dph ? rd_fn(dph_addr) : 32'h0;
            if (err_phase == 1) begin
                hresp = 1'b1; hready = 1'b1; err_phase = 2;
            end else begin
                hresp = 1'b0;
                if (dph && dph_idx == err_at && err_phase == 0) begin
                    hresp = 1'b1; hready = 1'b0; err_phase = 1;
                end else if (hold_ready) begin
                    hready = 1'b0;
                end else if (stall_en && wait_left > 0) begin
                    hready = 1'b0; wait_left--;
                end else begin
                    hready = 1'b1;
                    wait_left = stall_en ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    // Bus monitor and scoreboard: pops expectations as the DUT produces traffic.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                dph = 0; prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (htrans !== 2'b10 || haddr !== prev_addr || hwrite !== prev_write) begin
                        errors++;
                        $display("FAIL stall_hold: htrans=%b haddr=%h hwrite=%b, required 10 %h %b",
                                 htrans, haddr, hwrite, prev_addr, prev_write);
                    end
                end
                prev_stall = (htrans == 2'b10) && !hready;
                prev_addr  = haddr;
                prev_write = hwrite;
                if (dph && hready) begin
                    if (!hresp && dph_write) begin
                        checks++;
                        if (exp_wdata.size() == 0) begin
                            errors++;
                            $display("FAIL wdata_extra: hwdata=%h, required no write", hwdata);
                        end else begin
                            mexp = exp_wdata.pop_front();
                            if (hwdata !== mexp) begin
                                errors++;
                                $display("FAIL wdata: got %h, required %h", hwdata, mexp);
                            end
                        end
                    end
                    dph = 0;
                end
                if (htrans == 2'b10 && hready) begin
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL nonseq_extra: haddr=%h, required no transfer", haddr);
                    end else begin
                        mexp = exp_addr.pop_front();
                        if (haddr !== mexp) begin
                            errors++;
                            $display("FAIL haddr: got %h, required %h", haddr, mexp);
                        end
                    end
                    dph = 1; dph_addr = haddr; dph_write = hwrite; dph_idx = nonseq_cnt;
                    nonseq_cnt++;
                end
                if (snk_valid && snk_ready) begin
                    checks++;
                    if (exp_rdata.size() == 0) begin
                        errors++;
                        $display("FAIL snk_extra: snk_data=%h, required no word", snk_data);
                    end else begin
                        mexp = exp_rdata.pop_front();
                        if (snk_data !== mexp) begin
                            errors++;
                            $display("FAIL snk_data: got %h, required %h", snk_data, mexp);
                        end
                    end
                    rd_cnt++;
                end
                if (src_valid && src_ready) src_idx++;
                if (done) done_cnt++;
            end
        end
    end

    task automatic push_exp(input bit wr, input logic [31:0] a, input int n_addr, input int n_data);
        logic [31:0] base;
        logic [31:0] ai;
        base = a & ~32'h3;
        for (int i = 0; i < n_addr; i++) exp_addr.push_back(base + 32'(4 * i));
        for (int i = 0; i < n_data; i++) begin
            ai = base + 32'(4 * i);
            exp_wdata.push_back(SRC_BASE + 32'(src_idx + i));
            if (wr) void'(exp_wdata.pop_back());
            if (wr) exp_wdata.push_back(SRC_BASE + 32'(src_idx + i));
            else    exp_rdata.push_back(rd_fn(ai));
        end
        if (!wr) for (int i = 0; i < n_data; i++) void'(exp_wdata.pop_back());
    endtask

    task automatic start_run(input bit wr, input logic [31:0] a, input int n);
        @(negedge clk);
        cfg_write = wr; cfg_addr = a; cfg_words = 8'(n); cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_start = 0; cfg_write = 0; cfg_abort = 0; cfg_addr = '0; cfg_words = '0;
        src_valid = 0; snk_ready = 1'b1;
        idle(3);
        checks++;
        if ({busy, done, err, snk_valid, src_ready, hwrite} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000", {busy, done, err, snk_valid, src_ready, hwrite});
        end
        checks++;
        if (htrans !== 2'b00 || haddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: htrans=%b haddr=%h, required 00 0", htrans, haddr);
        end
        checks++;
        if (hwdata !== 32'h0 || snk_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: hwdata=%h snk_data=%h, required 0 0", hwdata, snk_data);
        end
        checks++;
        if ({hsize, hburst, hprot, hmastlock, hexcl} !== {3'b010, 3'b000, 4'b0011, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL constants: got %b, required 010000001100", {hsize, hburst, hprot, hmastlock, hexcl});
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_write;
        int d0, n0, s0;
        bit ok;
        d0 = done_cnt; n0 = nonseq_cnt; s0 = src_idx;
        stall_en = 0; src_valid = 1'b1;
        push_exp(1, 32'h2000_0003, 4, 4);
        start_run(1, 32'h2000_0003, 4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b, required 1", busy); end
        wait_done(200, ok);
        idle(3);
        checks++;
        if (!ok || done_cnt - d0 != 1) begin errors++; $display("FAIL write_done: pulses %0d, required 1", done_cnt - d0); end
        checks++;
        if (nonseq_cnt - n0 != 4 || src_idx - s0 != 4) begin
            errors++; $display("FAIL write_count: nonseq %0d pops %0d, required 4 4", nonseq_cnt - n0, src_idx - s0);
        end
        checks++;
        if (err !== 1'b0 || exp_addr.size() != 0 || exp_wdata.size() != 0) begin
            errors++; $display("FAIL write_end: err %b left %0d/%0d, required 0 0/0", err, exp_addr.size(), exp_wdata.size());
        end
        src_valid = 1'b0;
    endtask

    task automatic test_read_stall;
        int d0, n0, r0;
        bit ok, reached;
        d0 = done_cnt; n0 = nonseq_cnt; r0 = rd_cnt;
        stall_en = 1;
        push_exp(0, 32'h4000_0100, 128, 128);
        start_run(0, 32'h4000_0100, 128);
        reached = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rd_cnt - r0 >= 40) begin reached = 1; break; end
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL read_progress: words %0d, required 40", rd_cnt - r0); end
        snk_ready = 1'b0;
        idle(5);
        snk_ready = 1'b1;
        wait_done(6000, ok);
        stall_en = 0;
        idle(4);
        checks++;
        if (!ok || done_cnt - d0 != 1) begin errors++; $display("FAIL read_done: pulses %0d, required 1", done_cnt - d0); end
        checks++;
        if (rd_cnt - r0 != 128 || nonseq_cnt - n0 != 128) begin
            errors++; $display("FAIL read_count: words %0d nonseq %0d, required 128 128", rd_cnt - r0, nonseq_cnt - n0);
        end
        checks++;
        if (err !== 1'b0 || exp_addr.size() != 0 || exp_rdata.size() != 0) begin
            errors++; $display("FAIL read_end: err %b left %0d/%0d, required 0 0/0", err, exp_addr.size(), exp_rdata.size());
        end
    endtask

    task automatic test_zero_words;
        int d0, n0;
        d0 = done_cnt; n0 = nonseq_cnt;
        src_valid = 1'b1;
        start_run(1, 32'h3000_0000, 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_c1: busy %b done %b, required 1 0", busy, done); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || htrans !== 2'b00) begin
            errors++; $display("FAIL zero_c2: busy %b done %b htrans %b, required 0 1 00", busy, done, htrans);
        end
        // cfg_start in the done cycle must be ignored
        cfg_addr = 32'h3000_0040; cfg_words = 8'd2; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_c3: busy %b done %b, required 0 0", busy, done); end
        idle(10);
        checks++;
        if (nonseq_cnt != n0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_quiet: nonseq %0d done %0d busy %b, required 0 1 0", nonseq_cnt - n0, done_cnt - d0, busy);
        end
        src_valid = 1'b0;
    endtask

    task automatic test_error;
        int d0, n0;
        bit ok;
        d0 = done_cnt; n0 = nonseq_cnt;
        src_valid = 1'b1; err_phase = 0; err_at = nonseq_cnt + 2;
        push_exp(1, 32'h5000_0000, 3, 2);
        start_run(1, 32'h5000_0000, 8);
        wait_done(300, ok);
        idle(10);
        checks++;
        if (!ok || err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_set: done %b err %b busy %b, required 1 1 0", ok, err, busy); end
        checks++;
        if (nonseq_cnt - n0 != 3 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL err_count: nonseq %0d done %0d, required 3 1", nonseq_cnt - n0, done_cnt - d0);
        end
        err_at = -1;
        push_exp(1, 32'h5000_1000, 1, 1);
        start_run(1, 32'h5000_1000, 1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", err); end
        wait_done(100, ok);
        idle(3);
        checks++;
        if (!ok || err !== 1'b0 || exp_addr.size() != 0 || exp_wdata.size() != 0) begin
            errors++; $display("FAIL err_rerun: done %b err %b left %0d/%0d, required 1 0 0/0", ok, err, exp_addr.size(), exp_wdata.size());
        end
        src_valid = 1'b0;
    endtask

    task automatic test_abort;
        int n0, r0;
        bit ok, seen;
        n0 = nonseq_cnt; r0 = rd_cnt;
        hold_ready = 1;
        push_exp(0, 32'h6000_0000, 1, 1);
        start_run(0, 32'h6000_0000, 8);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (htrans === 2'b10) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_launch: htrans %b, required 10", htrans); end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        idle(2);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h6000_0000) begin
            errors++; $display("FAIL abort_hold: htrans %b haddr %h, required 10 60000000", htrans, haddr);
        end
        hold_ready = 0;
        wait_done(100, ok);
        idle(10);
        checks++;
        if (!ok || nonseq_cnt - n0 != 1 || rd_cnt - r0 != 1) begin
            errors++; $display("FAIL abort_end: done %b nonseq %0d words %0d, required 1 1 1", ok, nonseq_cnt - n0, rd_cnt - r0);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || exp_rdata.size() != 0) begin
            errors++; $display("FAIL abort_state: err %b busy %b left %0d, required 0 0 0", err, busy, exp_rdata.size());
        end
    endtask

    task automatic test_wrap_busy_start;
        int d0, n0;
        bit ok;
        d0 = done_cnt; n0 = nonseq_cnt;
        push_exp(0, 32'hFFFF_FFF8, 3, 3);
        start_run(0, 32'hFFFF_FFF8, 3);
        @(negedge clk);
        cfg_write = 1'b1; cfg_addr = 32'h0000_0100; cfg_words = 8'd5; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done(200, ok);
        idle(5);
        checks++;
        if (!ok || nonseq_cnt - n0 != 3 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL wrap_count: done %b nonseq %0d pulses %0d, required 1 3 1", ok, nonseq_cnt - n0, done_cnt - d0);
        end
        checks++;
        if (haddr !== 32'h0000_0000 || exp_addr.size() != 0 || exp_rdata.size() != 0) begin
            errors++; $display("FAIL wrap_end: haddr %h left %0d/%0d, required 00000000 0/0", haddr, exp_addr.size(), exp_rdata.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int n0, r0;
        bit reached;
        r0 = rd_cnt;
        push_exp(0, 32'h7000_0000, 8, 8);
        start_run(0, 32'h7000_0000, 8);
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_cnt - r0 >= 2 && htrans === 2'b10) begin reached = 1; break; end
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL rst_progress: words %0d, required 2 with NONSEQ up", rd_cnt - r0); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, snk_valid, src_ready, hwrite} !== 6'b0 || htrans !== 2'b00) begin
            errors++; $display("FAIL rst_flags: got %b htrans %b, required 000000 00", {busy, done, err, snk_valid, src_ready, hwrite}, htrans);
        end
        checks++;
        if (haddr !== 32'h0 || hwdata !== 32'h0 || snk_data !== 32'h0) begin
            errors++; $display("FAIL rst_data: haddr %h hwdata %h snk %h, required 0 0 0", haddr, hwdata, snk_data);
        end
        rst = 1'b0;
        exp_addr.delete(); exp_wdata.delete(); exp_rdata.delete();
        n0 = nonseq_cnt;
        idle(10);
        checks++;
        if (nonseq_cnt != n0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_quiet: nonseq %0d busy %b, required 0 0", nonseq_cnt - n0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_zero_words();
        test_error();
        test_abort();
        test_wrap_busy_start();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
